rob_retire: RTL
===============

// Module: rob_retire
// PURPOSE
// 16-entry reorder buffer with in-order, dual-width retirement. It is written by rename/dispatch (allocation, 2/cycle) and by the
// complete stage (up to 3 results/cycle, indexed by ROB tag). It is read at the head to retire up to 2 instructions/cycle.
// At retire it drives retire_flag_*/fp_ind_* back to the rename free pool, and commit_* to the physical register file.
// PARAMETERS
// DEPTH     16  ROB entries; power of two; tag width is log2(DEPTH)=4
// PREG_W    6   physical register index width (64 pregs)
// DATA_W    32  result width
// PORTS
// clk              in   1       rising-edge clock
// rst_n            in   1       asynchronous reset, active-low
// alloc_valid_1    in   1       allocate slot 1 (older instruction)
// alloc_pd_1       in   6       destination preg (0 = no destination)
// alloc_old_pd_1   in   6       previous preg mapped to the same arch reg; freed at retire
// alloc_store_1    in   1       1 = store (no register commit, no free)
// alloc_valid_2/alloc_pd_2/alloc_old_pd_2/alloc_store_2  in  1/6/6/1  same, slot 2 (younger)
// alloc_ready      out  1       1 when at least 2 entries are free
// alloc_idx_1      out  4       tag given to slot-1 allocation (= tail)
// alloc_idx_2      out  4       tag given to slot-2 allocation (= tail+1 if slot 1 valid, else tail)
// cmp_valid_k      in   1       completion port k (k=1..3)
// cmp_rob_k        in   4       ROB tag being completed
// cmp_data_k       in   32      ALU result
// retire_flag_1    out  1       slot-1 retired this cycle and frees fp_ind_1
// fp_ind_1         out  6       preg returned to free pool
// retire_flag_2/fp_ind_2  out 1/6  same, slot 2
// commit_we_1/2    out  1       write commit_data_* into p_regs[commit_pd_*]
// commit_pd_1/2    out  6       committed destination preg
// commit_data_1/2  out  32      committed value
// pr_flag          out  1       any instruction retired this cycle (incl. stores / no-dest)
// rob_count        out  5       occupied entries, 0..16
// BEHAVIOUR
// - Reset (async, rst_n=0): head=tail=0, count=0, every entry's v=0 and comp=0, and all registered outputs=0.
//   alloc_ready=1 after reset. Reset mid-operation discards all entries immediately.
// - Entry fields: v, store, pd, old_pd, result[31:0], comp. Pointers are 4-bit and wrap 15->0 naturally. count is 5-bit.
// - Allocation: accepted only if alloc_ready, which is computed from the registered count: count <= DEPTH-2.
//   Valid requests while alloc_ready=0 are dropped; upstream must stall. alloc_valid_2 without alloc_valid_1 goes to tail.
//   An accepted entry gets v=1 and comp=0 at the edge. tail advances by the number accepted (0/1/2).
// - Completion: on each edge, for each k with cmp_valid_k and entry[cmp_rob_k].v=1, set comp=1 and result=cmp_data_k.
//   Completions to an entry with v=0 are ignored. If two ports hit the same tag in one edge, the lowest k wins.
//   A completion and an allocation to the same tag in one edge: allocation wins (comp=0).
// - Retire decision uses registered state only, so a completion at edge N is retirable at edge N+1.
//   slot1 = entry[head].v & comp. slot2 = slot1 & entry[head+1].v & comp (strictly in order).
//   Retired entries get v=0 and head advances by 0/1/2.
// - Outputs are registered and valid for exactly the cycle after the retiring edge:
//   pr_flag=1 when slot1 retires.
//   For a retired non-store entry with pd!=0: retire_flag=1, fp_ind=old_pd, commit_we=1, commit_pd=pd, commit_data=result.
//   For stores or pd==0: retire_flag=0 and commit_we=0. fp_ind/commit_* hold 0.
// - Minimum latency: alloc edge E0, complete edge E1, retire edge E2; retire_flag_1 is high during E2..E3.
// - count_next = count + allocated - retired. Simultaneous alloc and retire at count=15 keeps count<=16.
//   At count=16 (full): alloc_ready=0, and retirement still proceeds.
// - Empty (count=0): no retire, and all flags are 0.
// TESTING
// 1 Reset: rst_n=0 mid-run with 5 entries live -> count=0, all flags 0, alloc_ready=1, alloc_idx_1=0.
// 2 Alloc 2 (pd=33/34, old_pd=3/4), complete both next cycle with 0x11/0x22 ->
//   one cycle later retire_flag_1/2=1, fp_ind=3/4, commit_data=0x11/0x22.
// 3 Out-of-order: complete tag1 before tag0 -> no retire until tag0 completes, then both retire in the same cycle, tag0 in slot 1.
// 4 Fill 16 entries -> alloc_ready=0 at count>=15; requests dropped. Retire 2 -> alloc_ready=1; tail wraps 15->0 correctly.
// 5 Same-tag collision: cmp_1 and cmp_3 to tag 5 with 0xA/0xB -> committed value 0xA.
// 6 Store at head (alloc_store_1=1) completes -> pr_flag=1, retire_flag_1=0, commit_we_1=0. The next entry still retires in slot 2.

Source files
------------

// File: rtl/rob_retire.sv
// rob_retire: 16-entry reorder buffer with in-order, dual-width retirement.
//   alloc_*   : two allocations per cycle from rename/dispatch; alloc_idx_* return the ROB tags.
//   cmp_*     : three completion ports, each writing a result and a completed bit by ROB tag.
//   retire_flag_*/fp_ind_* : pregs handed back to the free pool, one cycle after the retiring edge.
//   commit_*  : register-file writes for retired non-store entries with a destination.
//   pr_flag   : something retired (stores and no-destination entries included).
//   rob_count : occupied entries, 0..DEPTH.
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid_1,
  input  logic [PREG_W-1:0]          alloc_pd_1,
  input  logic [PREG_W-1:0]          alloc_old_pd_1,
  input  logic                       alloc_store_1,
  input  logic                       alloc_valid_2,
  input  logic [PREG_W-1:0]          alloc_pd_2,
  input  logic [PREG_W-1:0]          alloc_old_pd_2,
  input  logic                       alloc_store_2,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx_1,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx_2,
  input  logic                       cmp_valid_1,
  input  logic [$clog2(DEPTH)-1:0]   cmp_rob_1,
  input  logic [DATA_W-1:0]          cmp_data_1,
  input  logic                       cmp_valid_2,
  input  logic [$clog2(DEPTH)-1:0]   cmp_rob_2,
  input  logic [DATA_W-1:0]          cmp_data_2,
  input  logic                       cmp_valid_3,
  input  logic [$clog2(DEPTH)-1:0]   cmp_rob_3,
  input  logic [DATA_W-1:0]          cmp_data_3,
  output logic                       retire_flag_1,
  output logic [PREG_W-1:0]          fp_ind_1,
  output logic                       retire_flag_2,
  output logic [PREG_W-1:0]          fp_ind_2,
  output logic                       commit_we_1,
  output logic [PREG_W-1:0]          commit_pd_1,
  output logic [DATA_W-1:0]          commit_data_1,
  output logic                       commit_we_2,
  output logic [PREG_W-1:0]          commit_pd_2,
  output logic [DATA_W-1:0]          commit_data_2,
  output logic                       pr_flag,
  output logic [$clog2(DEPTH):0]     rob_count
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  logic              ent_v      [DEPTH];
  logic              ent_comp   [DEPTH];
  logic              ent_store  [DEPTH];
  logic [PREG_W-1:0] ent_pd     [DEPTH];
  logic [PREG_W-1:0] ent_old_pd [DEPTH];
  logic [DATA_W-1:0] ent_result [DEPTH];

  logic [TAG_W-1:0] head, tail, head_nx;
  logic [CNT_W-1:0] count, n_alloc, n_ret;
  logic             acc_1, acc_2, ret_1, ret_2, commit_1, commit_2;

  always_comb begin
    alloc_ready = (count <= CNT_W'(DEPTH - 2));
    alloc_idx_1 = tail;
    alloc_idx_2 = alloc_valid_1 ? tail + TAG_W'(1) : tail;
    acc_1       = alloc_valid_1 & alloc_ready;
    acc_2       = alloc_valid_2 & alloc_ready;
    head_nx     = head + TAG_W'(1);
    // Retire looks only at registered state; slot 2 never bypasses slot 1.
    ret_1       = ent_v[head] & ent_comp[head];
    ret_2       = ret_1 & ent_v[head_nx] & ent_comp[head_nx];
    commit_1    = ret_1 & ~ent_store[head] & (ent_pd[head] != '0);
    commit_2    = ret_2 & ~ent_store[head_nx] & (ent_pd[head_nx] != '0);
    n_alloc     = CNT_W'(acc_1) + CNT_W'(acc_2);
    n_ret       = CNT_W'(ret_1) + CNT_W'(ret_2);
    rob_count   = count;
  end

  // Later assignments win: port 3, then 2, then 1 so the lowest port takes a shared tag,
  // and allocation lands last so it overrides a same-edge completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_v[i]      <= 1'b0;
        ent_comp[i]   <= 1'b0;
        ent_store[i]  <= 1'b0;
        ent_pd[i]     <= '0;
        ent_old_pd[i] <= '0;
        ent_result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cmp_valid_3 && cmp_rob_3 == TAG_W'(i) && ent_v[i]) begin
          ent_comp[i]   <= 1'b1;
          ent_result[i] <= cmp_data_3;
        end
        if (cmp_valid_2 && cmp_rob_2 == TAG_W'(i) && ent_v[i]) begin
          ent_comp[i]   <= 1'b1;
          ent_result[i] <= cmp_data_2;
        end
        if (cmp_valid_1 && cmp_rob_1 == TAG_W'(i) && ent_v[i]) begin
          ent_comp[i]   <= 1'b1;
          ent_result[i] <= cmp_data_1;
        end
      end
      if (ret_1) ent_v[head]    <= 1'b0;
      if (ret_2) ent_v[head_nx] <= 1'b0;
      if (acc_1) begin
        ent_v[tail]      <= 1'b1;
        ent_comp[tail]   <= 1'b0;
        ent_store[tail]  <= alloc_store_1;
        ent_pd[tail]     <= alloc_pd_1;
        ent_old_pd[tail] <= alloc_old_pd_1;
      end
      if (acc_2) begin
        ent_v[alloc_idx_2]      <= 1'b1;
        ent_comp[alloc_idx_2]   <= 1'b0;
        ent_store[alloc_idx_2]  <= alloc_store_2;
        ent_pd[alloc_idx_2]     <= alloc_pd_2;
        ent_old_pd[alloc_idx_2] <= alloc_old_pd_2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      pr_flag       <= 1'b0;
      retire_flag_1 <= 1'b0;
      retire_flag_2 <= 1'b0;
      fp_ind_1      <= '0;
      fp_ind_2      <= '0;
      commit_we_1   <= 1'b0;
      commit_we_2   <= 1'b0;
      commit_pd_1   <= '0;
      commit_pd_2   <= '0;
      commit_data_1 <= '0;
      commit_data_2 <= '0;
    end else begin
      head          <= head + TAG_W'(n_ret);
      tail          <= tail + TAG_W'(n_alloc);
      count         <= count + n_alloc - n_ret;
      pr_flag       <= ret_1;
      retire_flag_1 <= commit_1;
      retire_flag_2 <= commit_2;
      commit_we_1   <= commit_1;
      commit_we_2   <= commit_2;
      fp_ind_1      <= commit_1 ? ent_old_pd[head]    : '0;
      fp_ind_2      <= commit_2 ? ent_old_pd[head_nx] : '0;
      commit_pd_1   <= commit_1 ? ent_pd[head]        : '0;
      commit_pd_2   <= commit_2 ? ent_pd[head_nx]     : '0;
      commit_data_1 <= commit_1 ? ent_result[head]    : '0;
      commit_data_2 <= commit_2 ? ent_result[head_nx] : '0;
    end
  end

endmodule
